// File: rtl/asd_conv_arbiter.sv
// ============================================================================
// Module   : asd_conv_arbiter
// Purpose  : Round-robin arbiter sharing one ASD/CSD converter among N_REQ
//            clients. Optional watchdog enabled by macro ASD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module asd_conv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int RES_W   = 34,
  parameter int ID_W    = 2,
  parameter int TMO_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      conv_start,
  output logic [DATA_W-1:0]         conv_din,
  input  logic                      conv_done,
  input  logic [RES_W-1:0]          conv_dout,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      busy,
  output logic                      tmo_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [ID_W:0]   c_n_req    = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] c_last_id  = ID_W'(N_REQ - 1);

  if ((2**ID_W < N_REQ) || (N_REQ < 2) || (TMO_CYC < 1) || (RES_W != 2*(DATA_W+1))) begin : g_bad_cfg
    $error("asd_conv_arbiter: inconsistent parameter set");
  end

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_win_id;
  logic [DATA_W-1:0]   r_conv_din;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [RES_W-1:0]    r_rsp_data;

  logic                w_win_found;
  logic [ID_W-1:0]     w_win_id;
  logic [ID_W:0]       w_scan_sum;
  logic [ID_W-1:0]     w_scan_idx;
  logic [N_REQ-1:0]    w_win_onehot;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_issue;
  logic [ID_W-1:0]     w_next_ptr;

  // Scan downwards so the client closest to r_rr_ptr is written last and wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_scan_sum  = '0;
    w_scan_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_scan_sum >= c_n_req) begin
        w_scan_sum = w_scan_sum - c_n_req;
      end
      w_scan_idx = w_scan_sum[ID_W-1:0];
      if (req[w_scan_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_win_onehot = '0;
    w_sel_data   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_win_id == ID_W'(k)) begin
        w_win_onehot[k] = 1'b1;
        w_sel_data      = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Grant is qualified by the live request so a client that drops in ISSUE gets no pulse.
  assign w_issue    = (r_state == S_ISSUE) && (|(req & w_win_onehot));
  assign w_next_ptr = (r_win_id == c_last_id) ? '0 : r_win_id + 1'b1;

  assign gnt        = w_issue ? w_win_onehot : '0;
  assign conv_start = w_issue;
  assign conv_din   = (r_state == S_ISSUE) ? w_sel_data : r_conv_din;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign busy       = (r_state != S_IDLE);

`ifdef ASD_ARB_TIMEOUT_EN
  localparam int              c_tmo_w    = $clog2(TMO_CYC + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO_CYC - 1);

  logic [c_tmo_w-1:0] r_tmo_cnt;
  logic               r_tmo_err;

  assign tmo_err = r_tmo_err;
`else
  assign tmo_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_win_id    <= '0;
      r_conv_din  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
`ifdef ASD_ARB_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_tmo_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_ARB;
          end
        end
        S_ARB: begin
          if (w_win_found) begin
            r_win_id <= w_win_id;
            r_state  <= S_ISSUE;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_conv_din <= w_sel_data;
            r_rr_ptr   <= w_next_ptr;
            r_state    <= S_WAIT;
`ifdef ASD_ARB_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
          end else begin
            r_state    <= S_ARB;
          end
        end
        S_WAIT: begin
          if (conv_done) begin
            r_rsp_data  <= conv_dout;
            r_rsp_id    <= r_win_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
`ifdef ASD_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == c_tmo_last) begin
            r_rsp_data  <= '0;
            r_rsp_id    <= r_win_id;
            r_rsp_valid <= 1'b1;
            r_tmo_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt   <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_asd_conv_arbiter.sv
// ============================================================================
// Module   : tb_asd_conv_arbiter
// Purpose  : Directed self-checking bench for asd_conv_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asd_conv_arbiter;

  localparam int c_n      = 4;
  localparam int c_dw     = 16;
  localparam int c_rw     = 34;
  localparam int c_idw    = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [c_n-1:0]       req = '0;
  logic [c_n*c_dw-1:0]  req_data = '0;
  logic [c_n-1:0]       gnt;
  logic                 conv_start;
  logic [c_dw-1:0]      conv_din;
  logic                 conv_done = 1'b0;
  logic [c_rw-1:0]      conv_dout = '0;
  logic                 rsp_valid;
  logic [c_idw-1:0]     rsp_id;
  logic [c_rw-1:0]      rsp_data;
  logic                 busy;
  logic                 tmo_err;

  int checks = 0;
  int errors = 0;

  asd_conv_arbiter #(
    .N_REQ(c_n), .DATA_W(c_dw), .RES_W(c_rw), .ID_W(c_idw), .TMO_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .conv_start(conv_start), .conv_din(conv_din), .conv_done(conv_done),
    .conv_dout(conv_dout), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits for the grant, checks it, then answers with a done after done_dly cycles.
  task automatic run_job(input string tag, input int exp_id, input logic [15:0] exp_din,
                         input int exp_lat, input int done_dly,
                         input logic [33:0] result, input bit drop_after);
    int cnt;
    logic [3:0] exp_gnt;
    cnt = 0;
    exp_gnt = 4'b0001 << exp_id;
    while (!conv_start && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_lat"}, 64'(cnt), 64'(exp_lat));
    chk({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    chk({tag, "_din"}, 64'(conv_din), 64'(exp_din));
    tick();
    if (drop_after) req = req & ~exp_gnt;
    chk({tag, "_gnt_off"}, 64'({gnt, conv_start}), 64'(0));
    repeat (done_dly - 1) tick();
    chk({tag, "_din_hold"}, 64'(conv_din), 64'(exp_din));
    conv_done = 1'b1;
    conv_dout = result;
    tick();
    conv_done = 1'b0;
    chk({tag, "_rvalid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_rid"}, 64'(rsp_id), 64'(exp_id));
    chk({tag, "_rdata"}, 64'(rsp_data), 64'(result));
  endtask

  initial begin
    int cnt;
    do_reset();
    chk("rst_out", 64'({gnt, conv_start, conv_din, rsp_valid, rsp_id, busy, tmo_err}), 64'(0));
    chk("rst_rdata", 64'(rsp_data), 64'(0));

    // Single job from client 1
    req_data[1*c_dw +: c_dw] = 16'h0007;
    req = 4'b0010;
    run_job("single", 1, 16'h0007, 2, 5, 34'h0_0000_0019, 1'b1);
    tick();
    chk("single_idle", 64'({rsp_valid, busy}), 64'(0));
    chk("single_hold", 64'(rsp_data), 64'h19);

    // Fairness with all four requesting continuously
    do_reset();
    for (int k = 0; k < c_n; k++) req_data[k*c_dw +: c_dw] = 16'(k + 1);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      run_job("fair", j % 4, 16'((j % 4) + 1), (j == 0) ? 2 : 3, 1,
              34'h100 + 34'(j), 1'b0);
    end
    req = 4'b0000;
    tick();
    chk("fair_idle", 64'(busy), 64'(0));

    // Request dropped while in ARB
    req = 4'b0100;
    tick();
    req = 4'b0000;
    chk("drop_arb", 64'({gnt, conv_start, busy}), 64'(1));
    tick();
    chk("drop_idle", 64'({gnt, conv_start, busy}), 64'(0));
    tick();
    chk("drop_quiet", 64'({gnt, conv_start, busy, rsp_valid}), 64'(0));

    // Stray done in IDLE and ARB
    conv_done = 1'b1;
    conv_dout = 34'h3FF;
    tick();
    chk("stray_idle", 64'(rsp_valid), 64'(0));
    req_data[0 +: c_dw] = 16'h00AA;
    req = 4'b0001;
    tick();
    tick();
    conv_done = 1'b0;
    chk("stray_arb", 64'(rsp_valid), 64'(0));
    chk("stray_rdata", 64'(rsp_data), 64'h104);
    chk("stray_gnt", 64'({gnt, conv_start}), 64'b00011);
    tick();
    req = 4'b0000;
    chk("wait_busy", 64'(busy), 64'(1));

    // Reset while waiting; a late done must be ignored
    reset = 1'b1;
    tick();
    reset = 1'b0;
    conv_done = 1'b1;
    conv_dout = 34'h2_AAAA_5555;
    tick();
    conv_done = 1'b0;
    chk("rst_mid_out", 64'({gnt, conv_start, conv_din, rsp_valid, rsp_id, busy, tmo_err}), 64'(0));
    chk("rst_mid_rdata", 64'(rsp_data), 64'(0));
    req_data[0 +: c_dw] = 16'h1111;
    req_data[3*c_dw +: c_dw] = 16'h3333;
    req = 4'b1001;
    run_job("post_rst0", 0, 16'h1111, 2, 2, 34'h1_2345_6789, 1'b1);
    run_job("post_rst3", 3, 16'h3333, 3, 1, 34'h0_0000_0033, 1'b1);
    tick();
    chk("tmo_err_clear", 64'(tmo_err), 64'(0));

`ifdef ASD_ARB_TIMEOUT_EN
    req_data[2*c_dw +: c_dw] = 16'h0042;
    req = 4'b0100;
    cnt = 0;
    while (!conv_start && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("tmo_gnt", 64'(gnt), 64'b0100);
    cnt = 0;
    tick();
    req = 4'b0000;
    cnt = 1;
    while (!rsp_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("tmo_lat", 64'(cnt), 64'(9));
    chk("tmo_rdata", 64'(rsp_data), 64'(0));
    chk("tmo_rid", 64'(rsp_id), 64'(2));
    chk("tmo_err_set", 64'(tmo_err), 64'(1));
    repeat (3) tick();
    chk("tmo_err_sticky", 64'(tmo_err), 64'(1));
    do_reset();
    chk("tmo_err_rst", 64'(tmo_err), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/asd_conv_arbiter.md
Name: asd_conv_arbiter

Overview:
- Shares one ASD/CSD conversion datapath (start/done handshake sequenced by its own controller) among N_REQ requesters.
- Round-robin arbitration; captures winner's operand, pulses converter start, waits for done, returns result tagged with requester ID.
- Sits between client blocks and the conversion controller/datapath pair; converter sees one job at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand width (binary two's complement)
- RES_W, 34, converter result width (2*(DATA_W+1), two bits per signed digit)
- ID_W, 2, requester ID width, must satisfy 2**ID_W >= N_REQ
- TMO_CYC, 255, watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- req  in  N_REQ  per-client request level, held until own gnt bit
- req_data  in  N_REQ*DATA_W  operands; client k at [k*DATA_W +: DATA_W]
- gnt  out  N_REQ  one-hot one-cycle grant pulse; operand captured that cycle
- conv_start  out  1  one-cycle start pulse to converter
- conv_din  out  DATA_W  operand to converter, stable from ISSUE until RESP
- conv_done  in  1  converter completion pulse
- conv_dout  in  RES_W  converter result, valid with conv_done
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  ID_W  requester index of result
- rsp_data  out  RES_W  registered result
- busy  out  1  high in every state except IDLE
- tmo_err  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset: state=IDLE, gnt=0, conv_start=0, conv_din=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, tmo_err=0, rr_ptr=0 (client 0 highest priority first). Reset mid-job abandons job; any later conv_done ignored.
- States: IDLE, ARB, ISSUE, WAIT, RESP.
- IDLE: |req=1 -> ARB; else stay.
- ARB: winner = first set req bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ; registered in win_id. No req set (dropped) -> IDLE, no grant.
- ISSUE: if req[win_id] still 1: gnt[win_id]=1, conv_din<=req_data[win_id], conv_start=1, rr_ptr<=(win_id+1) mod N_REQ, -> WAIT. Req dropped: -> ARB, no pulses.
- WAIT: on conv_done: rsp_data<=conv_dout, rsp_id<=win_id, -> RESP. conv_done outside WAIT ignored.
- RESP: rsp_valid=1 for exactly one cycle; -> IDLE.
- Latency: req seen in IDLE -> gnt/conv_start 2 cycles later; conv_done -> rsp_valid next cycle. Back-to-back jobs: RESP->IDLE->ARB->ISSUE, 3 cycles from rsp_valid to next conv_start.
- At most one gnt bit ever set; gnt and conv_start always coincide.
- Requester re-asserting req in its gnt cycle counts as a new request; round-robin prevents starvation: every pending client granted within N_REQ jobs.
- rsp_id/rsp_data hold last value until next RESP.

Optional Feature:
- Macro ASD_ARB_TIMEOUT_EN.
- Defined: counter cleared on entering WAIT, increments each WAIT cycle; reaching TMO_CYC without conv_done -> tmo_err<=1 (sticky until reset), rsp_valid pulsed with rsp_data=0, rsp_id=win_id, -> IDLE via RESP.
- Undefined: no counter; WAIT indefinite; tmo_err tied 0.

Test Plan:
- Single job: req=4'b0010, operand 16'h0007, converter done after 5 cycles returning 34'h0_0000_0019 -> gnt=4'b0010 and conv_start 2 cycles after req, conv_din=16'h0007, rsp_valid 1 cycle after done, rsp_id=1, rsp_data=34'h0_0000_0019.
- Fairness: req=4'b1111 held continuously, operands 1..4 -> grant order 0,1,2,3,0; each rsp_id matches grant order; no double gnt.
- Dropped request: req[2] asserted 1 cycle then deasserted during ARB -> no gnt, no conv_start, return to IDLE, busy low again within 2 cycles.
- Stray done: conv_done pulsed in IDLE and ARB -> no rsp_valid; rsp_data unchanged.
- Reset mid-WAIT: reset asserted while WAIT, then conv_done pulsed -> all outputs 0, no rsp_valid, next job from client 0 granted first.
- With ASD_ARB_TIMEOUT_EN, TMO_CYC=8, converter never done -> rsp_valid after 8 WAIT cycles + 1, rsp_data=0, tmo_err=1 held until reset.
